icache_way_sel: RTL and testbench
=================================

# icache_way_sel

Instruction-cache tag-compare and way-selection stage. Registers one lookup per accepted request, compares the request tag against every way's tag, and produces the one-hot hit vector. That vector drives the select input of the downstream one-hot payload mux, which picks the data way. The block also keeps per-set tree pseudo-LRU state and reports a one-hot victim way for refill on a miss.

## Interface
- WAY_NUM, 4, number of ways; power of two, ≥2
- SET_NUM, 64, number of sets; power of two
- TAG_WIDTH, 20, tag bits
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_vld  in  1  lookup request valid
- req_rdy  out  1  lookup request ready
- req_set  in  $clog2(SET_NUM)  set index
- req_tag  in  TAG_WIDTH  request tag
- way_vld  in  WAY_NUM  tag-array valid bits for req_set; sampled with req
- way_tag  in  TAG_WIDTH × [WAY_NUM] (unpacked)  tag-array tags for req_set
- refill_vld  in  1  refill write completed; touches PLRU
- refill_set  in  $clog2(SET_NUM)  refill set index
- refill_way_onehot  in  WAY_NUM  refilled way, exactly one bit set
- rsp_vld  out  1  lookup result valid
- rsp_rdy  in  1  consumer ready
- rsp_hit  out  1  any way hit
- rsp_hit_onehot  out  WAY_NUM  hit way; feeds data-mux select
- rsp_multi_hit  out  1  more than one way matched (error)
- rsp_victim_onehot  out  WAY_NUM  replacement way for this set
- rsp_set  out  $clog2(SET_NUM)  set index of the result

## Operation
- Accept is req_vld && req_rdy.
- req_rdy = !rsp_vld || rsp_rdy. This is a single output register, and a new accept can occur in the same cycle the old result drains.
- Match per way: way_vld[w] && (way_tag[w] == req_tag).
- rsp_hit is the OR of the match bits.
- rsp_multi_hit is 1 when two or more match bits are set. In that case rsp_hit_onehot keeps only the lowest-index matching way, so the output is always one-hot or zero.
- PLRU storage: WAY_NUM-1 bits per set. Node 0 is the root; the children of node n are 2n+1 (lower ways) and 2n+2 (upper ways).
  - Bit value 0 means the victim is in the lower subtree; 1 means the upper subtree.
- Touch of way w: every node on w's path is written to point away from w. Nodes off the path are unchanged.
- Victim selection, computed from req_set state at accept:
  - If any way_vld bit is 0, the victim is the lowest-index invalid way.
  - Otherwise the victim is found by walking the tree from the root.
- PLRU updates:
  - Accepted hit: touch the hit way in req_set.
  - Accepted miss: no update.
  - refill_vld: touch the refill way in refill_set.
- Same-cycle hit touch and refill touch:
  - Different sets: both updates apply.
  - Same set: the refill touch alone applies.
- A same-cycle PLRU update to req_set does not affect the victim reported for the request accepted in that cycle. The victim uses the pre-update state.
- refill_vld is independent of the request handshake and is never back-pressured.

## Timing
- Latency is 1 cycle: a request accepted in cycle N produces rsp_vld in cycle N+1.
- Throughput: 1 lookup per cycle while rsp_rdy = 1.
- While rsp_vld && !rsp_rdy, all rsp_* outputs hold stable, req_rdy = 0, and no PLRU hit update occurs. Refill updates still apply.
- PLRU updates become visible to lookups accepted in the following cycle.
- Reset values: rsp_vld, rsp_hit, rsp_multi_hit = 0; rsp_hit_onehot, rsp_victim_onehot, rsp_set = 0; all PLRU bits = 0 (victim is way 0); req_rdy = 1 in the cycle after reset deasserts.
- Reset asserted mid-operation discards any pending result the next edge and clears all PLRU state. Refill and request inputs are ignored while rst = 1.

## Test plan
- Reset, then miss on set 3 with all way_vld = 4'b1111:
  - Cycle N+1: rsp_hit = 0, rsp_victim_onehot = 4'b0001.
- PLRU walk on set 5 (ways all valid):
  - Hit way 0, then miss: victim 4'b0100.
  - Hit way 2, then miss: victim 4'b0010.
- Invalid preference: way_vld = 4'b1011 on a miss → victim 4'b0100, regardless of PLRU state.
- Multi-hit: ways 1 and 3 both hold req_tag and are valid → rsp_hit = 1, rsp_multi_hit = 1, rsp_hit_onehot = 4'b0010.
- Back-pressure:
  - Hold rsp_rdy = 0 for 3 cycles with req_vld = 1: outputs stay stable and req_rdy = 0.
  - Release: the next request is accepted in the same cycle, and its result appears the following cycle.
- Conflict on set 7, starting from reset: a hit on way 1 and refill_vld to way 3 in the same cycle → only the way-3 touch applies; the next miss on set 7 reports victim 4'b0001.

Source files
------------

// File: rtl/icache_way_sel_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_way_sel_if
//  Description : Lookup request, tag-array read, refill notification and
//                lookup response bundle for the I-cache way-select stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface icache_way_sel_if #(
    parameter int WAY_NUM   = 4,
    parameter int SET_NUM   = 64,
    parameter int TAG_WIDTH = 20
);
    localparam int c_SET_W = $clog2(SET_NUM);

    // Lookup request and the tag-array read for req_set
    logic                   req_vld;
    logic                   req_rdy;
    logic [c_SET_W-1:0]     req_set;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic [WAY_NUM-1:0]     way_vld;
    logic [TAG_WIDTH-1:0]   way_tag [WAY_NUM];

    // Refill completion, touches replacement state
    logic                   refill_vld;
    logic [c_SET_W-1:0]     refill_set;
    logic [WAY_NUM-1:0]     refill_way_onehot;

    // Lookup response
    logic                   rsp_vld;
    logic                   rsp_rdy;
    logic                   rsp_hit;
    logic [WAY_NUM-1:0]     rsp_hit_onehot;
    logic                   rsp_multi_hit;
    logic [WAY_NUM-1:0]     rsp_victim_onehot;
    logic [c_SET_W-1:0]     rsp_set;

    // Requester / consumer side
    modport master (
        output req_vld, req_set, req_tag, way_vld, way_tag,
        output refill_vld, refill_set, refill_way_onehot,
        output rsp_rdy,
        input  req_rdy,
        input  rsp_vld, rsp_hit, rsp_hit_onehot, rsp_multi_hit,
        input  rsp_victim_onehot, rsp_set
    );

    // Way-select stage side
    modport slave (
        input  req_vld, req_set, req_tag, way_vld, way_tag,
        input  refill_vld, refill_set, refill_way_onehot,
        input  rsp_rdy,
        output req_rdy,
        output rsp_vld, rsp_hit, rsp_hit_onehot, rsp_multi_hit,
        output rsp_victim_onehot, rsp_set
    );
endinterface
`default_nettype wire

// File: rtl/icache_way_sel.sv
`default_nettype none
// ============================================================================
//  Module      : icache_way_sel
//  Description : I-cache tag compare and way selection. Registers one lookup
//                per accepted request, produces a one-hot hit vector for the
//                downstream data mux, and reports a one-hot refill victim
//                from per-set tree pseudo-LRU state.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_way_sel #(
    parameter int WAY_NUM   = 4,
    parameter int SET_NUM   = 64,
    parameter int TAG_WIDTH = 20
) (
    input  logic              clk,
    input  logic              rst,
    icache_way_sel_if.slave   bus
);
    localparam int c_SET_W = $clog2(SET_NUM);
    localparam int c_WAY_W = $clog2(WAY_NUM);
    localparam logic [WAY_NUM-1:0] c_ONE = WAY_NUM'(1);

    // ------------------------------------------------------------------------
    // Tree PLRU helpers. Node 0 is the root, node n has children 2n+1 (lower
    // ways) and 2n+2 (upper ways). A node value of 1 points the victim at the
    // upper subtree. Level l of the tree holds nodes (2^l - 1) .. (2^(l+1) - 2).
    // ------------------------------------------------------------------------

    // Point every node on the path to 'way' away from it
    function automatic logic [WAY_NUM-2:0] f_plru_touch(
        input logic [WAY_NUM-2:0] bits,
        input logic [c_WAY_W-1:0] way
    );
        logic [WAY_NUM-2:0] nxt;
        int                 w_int;
        nxt   = bits;
        w_int = int'(way);
        for (int l = 0; l < c_WAY_W; l++) begin
            for (int j = 0; j < (1 << l); j++) begin
                if ((w_int >> (c_WAY_W - l)) == j) begin
                    // way in lower half of this node -> victim goes upper (1)
                    nxt[(1 << l) - 1 + j] = ((w_int >> (c_WAY_W - 1 - l)) & 1) == 0;
                end
            end
        end
        return nxt;
    endfunction

    // Follow the node bits from the root down to a leaf
    function automatic logic [WAY_NUM-1:0] f_plru_victim(
        input logic [WAY_NUM-2:0] bits
    );
        logic [WAY_NUM-1:0] oh;
        int                 n;
        n = 0;
        for (int l = 0; l < c_WAY_W; l++) begin
            n = 2 * n + 1 + (bits[n] ? 1 : 0);
        end
        for (int w = 0; w < WAY_NUM; w++) begin
            oh[w] = (w == n - (WAY_NUM - 1));
        end
        return oh;
    endfunction

    // Index of the lowest set bit (callers pass a one-hot vector)
    function automatic logic [c_WAY_W-1:0] f_onehot_to_idx(
        input logic [WAY_NUM-1:0] oh
    );
        logic [c_WAY_W-1:0] idx;
        idx = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (oh[i]) idx = c_WAY_W'(i);
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WAY_NUM-2:0]   r_plru [SET_NUM];

    logic                 r_rsp_vld;
    logic                 r_rsp_hit;
    logic [WAY_NUM-1:0]   r_rsp_hit_onehot;
    logic                 r_rsp_multi_hit;
    logic [WAY_NUM-1:0]   r_rsp_victim_onehot;
    logic [c_SET_W-1:0]   r_rsp_set;

    // ------------------------------------------------------------------------
    // Combinational lookup
    // ------------------------------------------------------------------------
    logic [WAY_NUM-1:0]   w_match;
    logic [WAY_NUM-1:0]   w_hit_onehot;
    logic                 w_hit;
    logic                 w_multi_hit;
    logic [WAY_NUM-1:0]   w_invalid;
    logic [WAY_NUM-1:0]   w_invalid_onehot;
    logic [WAY_NUM-1:0]   w_victim_onehot;
    logic [WAY_NUM-2:0]   w_plru_req;
    logic [WAY_NUM-2:0]   w_plru_refill;
    logic [WAY_NUM-2:0]   w_hit_next;
    logic [WAY_NUM-2:0]   w_refill_next;
    logic                 w_req_rdy;
    logic                 w_accept;
    logic                 w_hit_upd;

    generate
        for (genvar g = 0; g < WAY_NUM; g++) begin : g_match
            assign w_match[g] = bus.way_vld[g] && (bus.way_tag[g] == bus.req_tag);
        end
    endgenerate

    // Single output register: a new lookup can enter as the old one drains
    assign w_req_rdy = !r_rsp_vld || bus.rsp_rdy;
    assign w_accept  = bus.req_vld && w_req_rdy;

    // Isolate the lowest match so the data-mux select is never multi-hot;
    // any second match bit surviving (x & (x-1)) flags a multi-hit.
    assign w_hit_onehot = w_match & (~w_match + c_ONE);
    assign w_hit        = |w_match;
    assign w_multi_hit  = |(w_match & (w_match - c_ONE));

    // Empty ways are always filled before anything is evicted
    assign w_invalid        = ~bus.way_vld;
    assign w_invalid_onehot = w_invalid & (~w_invalid + c_ONE);

    assign w_plru_req    = r_plru[bus.req_set];
    assign w_plru_refill = r_plru[bus.refill_set];

    // Victim uses the stored state, before any same-cycle touch lands
    assign w_victim_onehot = (|w_invalid) ? w_invalid_onehot
                                          : f_plru_victim(w_plru_req);

    assign w_hit_next    = f_plru_touch(w_plru_req, f_onehot_to_idx(w_hit_onehot));
    assign w_refill_next = f_plru_touch(w_plru_refill,
                                        f_onehot_to_idx(bus.refill_way_onehot));

    // A refill into the same set overrides the hit touch
    assign w_hit_upd = w_accept && w_hit &&
                       !(bus.refill_vld && (bus.refill_set == bus.req_set));

    // ------------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------------

    // PLRU storage: hit touch and refill touch, refill is never stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SET_NUM; s++) begin
                r_plru[s] <= '0;
            end
        end else begin
            if (w_hit_upd) begin
                r_plru[bus.req_set] <= w_hit_next;
            end
            if (bus.refill_vld) begin
                r_plru[bus.refill_set] <= w_refill_next;
            end
        end
    end

    // Response register: load on accept, drain on consumer ready, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_vld           <= 1'b0;
            r_rsp_hit           <= 1'b0;
            r_rsp_hit_onehot    <= '0;
            r_rsp_multi_hit     <= 1'b0;
            r_rsp_victim_onehot <= '0;
            r_rsp_set           <= '0;
        end else if (w_accept) begin
            r_rsp_vld           <= 1'b1;
            r_rsp_hit           <= w_hit;
            r_rsp_hit_onehot    <= w_hit_onehot;
            r_rsp_multi_hit     <= w_multi_hit;
            r_rsp_victim_onehot <= w_victim_onehot;
            r_rsp_set           <= bus.req_set;
        end else if (bus.rsp_rdy) begin
            r_rsp_vld           <= 1'b0;
        end
    end

    assign bus.req_rdy           = w_req_rdy;
    assign bus.rsp_vld           = r_rsp_vld;
    assign bus.rsp_hit           = r_rsp_hit;
    assign bus.rsp_hit_onehot    = r_rsp_hit_onehot;
    assign bus.rsp_multi_hit     = r_rsp_multi_hit;
    assign bus.rsp_victim_onehot = r_rsp_victim_onehot;
    assign bus.rsp_set           = r_rsp_set;

endmodule
`default_nettype wire

// File: tb/tb_icache_way_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_way_sel
//  Description : Directed self-checking bench for icache_way_sel.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_way_sel;
    localparam int c_WAY_NUM   = 4;
    localparam int c_SET_NUM   = 64;
    localparam int c_TAG_WIDTH = 20;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    icache_way_sel_if #(
        .WAY_NUM   (c_WAY_NUM),
        .SET_NUM   (c_SET_NUM),
        .TAG_WIDTH (c_TAG_WIDTH)
    ) bus ();

    icache_way_sel #(
        .WAY_NUM   (c_WAY_NUM),
        .SET_NUM   (c_SET_NUM),
        .TAG_WIDTH (c_TAG_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tags(input logic [19:0] t0, input logic [19:0] t1,
                            input logic [19:0] t2, input logic [19:0] t3);
        bus.way_tag[0] = t0;
        bus.way_tag[1] = t1;
        bus.way_tag[2] = t2;
        bus.way_tag[3] = t3;
    endtask

    // One request through one edge, request dropped afterwards
    task automatic issue(input logic [5:0] set, input logic [19:0] tag, input logic [3:0] vld);
        bus.req_vld = 1'b1;
        bus.req_set = set;
        bus.req_tag = tag;
        bus.way_vld = vld;
        tick();
        bus.req_vld = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req_vld           = 1'b0;
        bus.req_set           = '0;
        bus.req_tag           = '0;
        bus.way_vld           = '0;
        bus.refill_vld        = 1'b0;
        bus.refill_set        = '0;
        bus.refill_way_onehot = '0;
        bus.rsp_rdy           = 1'b1;
        set_tags(20'h0, 20'h0, 20'h0, 20'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_rsp_vld",    32'(bus.rsp_vld), 0);
        chk("rst_rsp_hit",    32'(bus.rsp_hit), 0);
        chk("rst_multi",      32'(bus.rsp_multi_hit), 0);
        chk("rst_hit_oh",     32'(bus.rsp_hit_onehot), 0);
        chk("rst_victim",     32'(bus.rsp_victim_onehot), 0);
        chk("rst_set",        32'(bus.rsp_set), 0);
        chk("rst_req_rdy",    32'(bus.req_rdy), 1);

        // Miss on set 3, all valid, fresh PLRU -> way 0
        set_tags(20'h00001, 20'h00002, 20'h00003, 20'h00004);
        issue(6'd3, 20'h00099, 4'b1111);
        chk("miss3_vld",      32'(bus.rsp_vld), 1);
        chk("miss3_hit",      32'(bus.rsp_hit), 0);
        chk("miss3_victim",   32'(bus.rsp_victim_onehot), 32'b0001);
        chk("miss3_set",      32'(bus.rsp_set), 3);

        // PLRU walk on set 5
        set_tags(20'h000A0, 20'h000A1, 20'h000A2, 20'h000A3);
        issue(6'd5, 20'h000A0, 4'b1111);
        chk("s5_hit0_hit",    32'(bus.rsp_hit), 1);
        chk("s5_hit0_oh",     32'(bus.rsp_hit_onehot), 32'b0001);
        chk("s5_hit0_multi",  32'(bus.rsp_multi_hit), 0);
        issue(6'd5, 20'h0BEEF, 4'b1111);
        chk("s5_miss1_hit",   32'(bus.rsp_hit), 0);
        chk("s5_miss1_vict",  32'(bus.rsp_victim_onehot), 32'b0100);
        issue(6'd5, 20'h000A2, 4'b1111);
        chk("s5_hit2_oh",     32'(bus.rsp_hit_onehot), 32'b0100);
        issue(6'd5, 20'h0BEEF, 4'b1111);
        chk("s5_miss2_vict",  32'(bus.rsp_victim_onehot), 32'b0010);

        // Invalid way preferred over PLRU (which points at way 1); tag of the
        // invalid way matches but must not hit
        issue(6'd5, 20'h000A2, 4'b1011);
        chk("inv_hit",        32'(bus.rsp_hit), 0);
        chk("inv_victim",     32'(bus.rsp_victim_onehot), 32'b0100);

        // Multi-hit on ways 1 and 3
        set_tags(20'h00001, 20'h00055, 20'h00003, 20'h00055);
        issue(6'd9, 20'h00055, 4'b1111);
        chk("multi_hit",      32'(bus.rsp_hit), 1);
        chk("multi_flag",     32'(bus.rsp_multi_hit), 1);
        chk("multi_oh",       32'(bus.rsp_hit_onehot), 32'b0010);

        // Back-pressure: R1 miss on set 10, R2 hit way 3 on set 11 waits
        set_tags(20'h00010, 20'h00011, 20'h00012, 20'h00013);
        issue(6'd10, 20'h0FFFF, 4'b1111);
        chk("bp_r1_vld",      32'(bus.rsp_vld), 1);
        bus.rsp_rdy = 1'b0;
        bus.req_vld = 1'b1;
        bus.req_set = 6'd11;
        bus.req_tag = 20'h00013;
        bus.way_vld = 4'b1111;
        #1;
        chk("bp_rdy_low",     32'(bus.req_rdy), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_vld",    32'(bus.rsp_vld), 1);
            chk("bp_hold_set",    32'(bus.rsp_set), 10);
            chk("bp_hold_hit",    32'(bus.rsp_hit), 0);
            chk("bp_hold_vict",   32'(bus.rsp_victim_onehot), 32'b0001);
            chk("bp_hold_rdy",    32'(bus.req_rdy), 0);
        end
        bus.rsp_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(bus.req_rdy), 1);
        tick();
        bus.req_vld = 1'b0;
        chk("bp_r2_vld",      32'(bus.rsp_vld), 1);
        chk("bp_r2_set",      32'(bus.rsp_set), 11);
        chk("bp_r2_oh",       32'(bus.rsp_hit_onehot), 32'b1000);
        tick();
        chk("bp_drain_vld",   32'(bus.rsp_vld), 0);

        // Mid-operation reset: pending result dropped, PLRU cleared, refill
        // during reset ignored (set 5 would otherwise point at way 2)
        set_tags(20'h000A0, 20'h000A1, 20'h000A2, 20'h000A3);
        issue(6'd5, 20'h000A0, 4'b1111);
        chk("mr_pending",     32'(bus.rsp_vld), 1);
        rst = 1'b1;
        bus.refill_vld        = 1'b1;
        bus.refill_set        = 6'd5;
        bus.refill_way_onehot = 4'b0001;
        tick();
        rst = 1'b0;
        bus.refill_vld = 1'b0;
        chk("mr_rsp_vld",     32'(bus.rsp_vld), 0);
        issue(6'd5, 20'h0BEEF, 4'b1111);
        chk("mr_victim",      32'(bus.rsp_victim_onehot), 32'b0001);

        // Same-set conflict on set 7: only the refill touch of way 3 applies
        set_tags(20'h000B0, 20'h000B1, 20'h000B2, 20'h000B3);
        bus.refill_vld        = 1'b1;
        bus.refill_set        = 6'd7;
        bus.refill_way_onehot = 4'b1000;
        issue(6'd7, 20'h000B1, 4'b1111);
        bus.refill_vld = 1'b0;
        chk("cf_hit_oh",      32'(bus.rsp_hit_onehot), 32'b0010);
        issue(6'd7, 20'h0BEEF, 4'b1111);
        chk("cf_victim",      32'(bus.rsp_victim_onehot), 32'b0001);

        // Different sets: hit way 0 on set 12, refill way 0 on set 13
        bus.refill_vld        = 1'b1;
        bus.refill_set        = 6'd13;
        bus.refill_way_onehot = 4'b0001;
        issue(6'd12, 20'h000B0, 4'b1111);
        bus.refill_vld = 1'b0;
        issue(6'd12, 20'h0BEEF, 4'b1111);
        chk("ds_set12_vict",  32'(bus.rsp_victim_onehot), 32'b0100);
        issue(6'd13, 20'h0BEEF, 4'b1111);
        chk("ds_set13_vict",  32'(bus.rsp_victim_onehot), 32'b0100);

        // Same-cycle refill to the request's set does not change its victim
        bus.refill_vld        = 1'b1;
        bus.refill_set        = 6'd14;
        bus.refill_way_onehot = 4'b0001;
        issue(6'd14, 20'h0BEEF, 4'b1111);
        bus.refill_vld = 1'b0;
        chk("pre_upd_vict",   32'(bus.rsp_victim_onehot), 32'b0001);
        issue(6'd14, 20'h0BEEF, 4'b1111);
        chk("post_upd_vict",  32'(bus.rsp_victim_onehot), 32'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
